// File: rtl/light_show_ctrl.sv
// Run controller for the 16-LED rotating-window display: button debounce,
// run/pause/stop FSM, rate-selectable step ticks and the wrapping lit window.
module light_show_ctrl #(
    parameter int unsigned TICK_BASE  = 100_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_stop,
    input  logic        btn_dir,
    input  logic [2:0]  width_sel,
    input  logic [1:0]  speed_sel,
    output logic [15:0] led,
    output logic [1:0]  state,
    output logic        step_pulse
);

    // Counter only has to hold 0..DEB_CYCLES-1; the flip happens on the last count.
    localparam int unsigned   DebW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CYCLES - 1);

    // Button index: 0 = start, 1 = stop, 2 = dir
    localparam int unsigned BtnStart = 0;
    localparam int unsigned BtnStop  = 1;
    localparam int unsigned BtnDir   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10
    } state_e;

    logic [2:0]            w_btn_raw;
    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_level;
    logic [2:0][DebW-1:0]  r_dcnt;
    logic [2:0]            w_press;

    state_e                r_state;
    logic [3:0]            r_pos;
    logic [3:0]            r_width;
    logic                  r_dir;
    logic [31:0]           r_cnt;
    logic                  r_step;
    logic [15:0]           r_led;

    logic [31:0]           w_period;
    logic                  w_step;
    logic [15:0]           w_window;

    assign w_btn_raw = {btn_dir, btn_stop, btn_start};

    // Synchronize raw buttons and accept a new level after DEB_CYCLES differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_dcnt  <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DebMax) begin
                    r_level[i] <= r_sync2[i];
                    r_dcnt[i]  <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Press strobe fires in the cycle the accepted level is about to rise
    always_comb begin
        w_press = '0;
        for (int i = 0; i < 3; i++) begin
            w_press[i] = r_sync2[i] & ~r_level[i] & (r_dcnt[i] == DebMax);
        end
    end

    // Step period and step decision; >= lets a shortened period fire immediately
    always_comb begin
        w_period = 32'(TICK_BASE) >> speed_sel;
        w_step   = (r_state == StRun) && (r_cnt >= (w_period - 32'd1)) && !w_press[BtnStop];
    end

    // Window mask: bit i lit when its distance above pos (mod 16) is below width
    always_comb begin
        w_window = '0;
        for (int i = 0; i < 16; i++) begin
            w_window[i] = ((4'(i) - r_pos) < r_width);
        end
    end

    // Run/pause/stop FSM with tick counter, window position and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_pos   <= '0;
            r_width <= 4'd1;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_led   <= '0;
        end else begin
            r_step <= w_step;
            if (w_press[BtnDir]) begin
                r_dir <= ~r_dir;
            end
            if (w_press[BtnStop]) begin
                r_state <= StIdle;
                r_pos   <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_cnt <= '0;
                        if (w_press[BtnStart]) begin
                            r_state <= StRun;
                            r_width <= {1'b0, width_sel} + 4'd1;
                        end
                    end
                    StRun: begin
                        if (w_step) begin
                            r_cnt   <= '0;
                            r_pos   <= r_dir ? (r_pos - 4'd1) : (r_pos + 4'd1);
                            r_width <= {1'b0, width_sel} + 4'd1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                        if (w_press[BtnStart]) begin
                            r_state <= StPause;
                        end
                    end
                    StPause: begin
                        if (w_press[BtnStart]) begin
                            r_state <= StRun;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
            r_led <= (r_state == StIdle) ? 16'h0000 : w_window;
        end
    end

    assign led        = r_led;
    assign state      = r_state;
    assign step_pulse = r_step;

endmodule

// File: tb/tb_light_show_ctrl.sv
// Scoreboard bench for light_show_ctrl: expected LED patterns after each step
// are queued as stimulus is applied and checked when the step occurs.
module tb_light_show_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_start;
    logic        btn_stop;
    logic        btn_dir;
    logic [2:0]  width_sel;
    logic [1:0]  speed_sel;
    logic [15:0] led;
    logic [1:0]  state;
    logic        step_pulse;

    light_show_ctrl #(
        .TICK_BASE  (8),
        .DEB_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_dir    (btn_dir),
        .width_sel  (width_sel),
        .speed_sel  (speed_sel),
        .led        (led),
        .state      (state),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] led;
        int          gap;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_step = 0;
    int   gap_seen  = 0;
    logic step_d    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Window with wrap, built as a 32-bit run of ones folded back onto 16 bits
    function automatic logic [15:0] win(input int pos, input int w);
        logic [31:0] v;
        v = ((32'd1 << w) - 32'd1) << pos;
        return v[15:0] | v[31:16];
    endfunction

    function automatic void push_exp(input logic [15:0] l, input int g);
        exp_t e;
        e.led = l;
        e.gap = g;
        sb_q.push_back(e);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // LED is valid one cycle after step_pulse; gap is measured step to step
    always @(negedge clk) begin
        if (step_d && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("led_after_step", led, mon_e.led);
            if (mon_e.gap != 0) check("step_gap", gap_seen, mon_e.gap);
        end
        if (step_pulse === 1'b1) begin
            gap_seen  = cyc - last_step;
            last_step = cyc;
        end
        step_d = step_pulse;
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_start = v;
            1: btn_stop  = v;
            default: btn_dir = v;
        endcase
    endtask

    task automatic press(input int which, input int n);
        set_btn(which, 1'b1);
        repeat (n) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, state, s);
    endtask

    task automatic wait_empty(input int budget, input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int n;
        int changes;
        rst       = 1'b1;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_dir   = 1'b0;
        width_sel = 3'd2;
        speed_sel = 2'd0;

        // Reset state
        @(negedge clk);
        check("rst_led", led, 16'h0000);
        check("rst_state", state, 2'b00);
        check("rst_step", step_pulse, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Start, width 3, speed 0: RUN within 8 cycles, then steps every 8
        push_exp(16'h000E, 0);
        push_exp(16'h001C, 8);
        btn_start = 1'b1;
        wait_state(2'b01, 8, "start_to_run");
        @(negedge clk);
        check("run_led0", led, 16'h0007);
        repeat (3) @(negedge clk);
        btn_start = 1'b0;
        wait_empty(40, "first_steps");

        // Width 4 up to pos 15, including the wrap through bit 0
        width_sel = 3'd3;
        for (int p = 3; p <= 15; p++) push_exp(win(p, 4), 8);
        wait_empty(130, "wrap_steps");

        // Bouncy 1010 pulse must not pause; steps keep coming
        for (int p = 0; p <= 2; p++) push_exp(win(p, 4), 8);
        btn_start = 1'b1; @(negedge clk);
        btn_start = 1'b0; @(negedge clk);
        btn_start = 1'b1; @(negedge clk);
        btn_start = 1'b0; @(negedge clk);
        wait_empty(40, "bounce_steps");
        check("bounce_state", state, 2'b01);

        // Pause right after the pos-3 step; cnt freezes at 6
        n = 0;
        while (step_pulse !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sync_step", step_pulse, 1'b1);
        btn_start = 1'b1;
        repeat (6) @(negedge clk);
        check("pause_state", state, 2'b10);
        check("pause_led", led, win(3, 4));
        repeat (4) @(negedge clk);
        btn_start = 1'b0;
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (led !== win(3, 4) || step_pulse !== 1'b0) changes++;
        end
        check("pause_frozen", changes, 0);
        check("pause_hold", state, 2'b10);

        // Resume: frozen cnt of 6 means a step 2 cycles after RUN, 8 after the press
        push_exp(win(4, 4), 0);
        btn_start = 1'b1;
        n = 0;
        while (step_pulse !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        btn_start = 1'b0;
        check("resume_latency", n, 8);
        wait_empty(10, "resume_step");

        // Stop, then start at pos 0 width 1 and toggle dir while running
        press(1, 10);
        check("stop_state", state, 2'b00);
        check("stop_led", led, 16'h0000);
        width_sel = 3'd0;
        push_exp(16'h8000, 0);
        push_exp(16'h4000, 8);
        btn_start = 1'b1;
        repeat (6) @(negedge clk);
        check("dir_run", state, 2'b01);
        btn_start = 1'b0;
        btn_dir   = 1'b1;
        @(negedge clk);
        check("dir_led0", led, 16'h0001);
        repeat (9) @(negedge clk);
        btn_dir = 1'b0;
        wait_empty(30, "dir_steps");

        // Stop and start in the same cycle: stop wins
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        repeat (6) @(negedge clk);
        check("stop_beats_start", state, 2'b00);
        @(negedge clk);
        check("stop_beats_led", led, 16'h0000);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        repeat (10) @(negedge clk);
        check("still_idle", state, 2'b00);
        press(2, 10);  // dir back to 0 while idle

        // speed 0 -> 3 at cnt 5: step next cycle, then every cycle
        btn_start = 1'b1;
        repeat (6) @(negedge clk);
        check("spd_run", state, 2'b01);
        btn_start = 1'b0;
        repeat (5) @(negedge clk);
        check("spd_no_step_yet", step_pulse, 1'b0);
        push_exp(16'h0002, 0);
        push_exp(16'h0004, 1);
        push_exp(16'h0008, 1);
        speed_sel = 2'd3;
        @(negedge clk);
        check("spd_step_next", step_pulse, 1'b1);
        wait_empty(10, "fast_steps");

        // speed 1: steps every 4 cycles from a fresh start
        press(1, 10);
        wait_state(2'b00, 10, "stop2_state");
        speed_sel = 2'd1;
        push_exp(16'h0002, 0);
        push_exp(16'h0004, 4);
        push_exp(16'h0008, 4);
        press(0, 10);
        wait_empty(40, "speed1_steps");

        // Asynchronous reset mid-run, between clock edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_led", led, 16'h0000);
        check("arst_state", state, 2'b00);
        check("arst_step", step_pulse, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        width_sel = 3'd1;
        speed_sel = 2'd0;
        push_exp(16'h0006, 0);
        btn_start = 1'b1;
        wait_state(2'b01, 8, "post_rst_run");
        @(negedge clk);
        check("post_rst_led", led, 16'h0003);
        repeat (4) @(negedge clk);
        btn_start = 1'b0;
        wait_empty(30, "post_rst_step");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
